flag_intr_unit: RTL and testbench

//  Flag and interrupt front end of the RAT MCU. Holds the C/Z flags, their shadow copies and
//  the interrupt-enable bit, all under ControlUnit command (FLG_*, I_SET/I_CLR).

---
 rtl/rat_pkg.sv | 17 +
 rtl/intr_sync.sv | 45 ++++
 rtl/flag_intr_unit.sv | 116 +++++++++++
 tb/tb_flag_intr_unit.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rat_pkg.sv
// rat_pkg
//   Shared definitions for the RAT MCU datapath and ControlUnit.
//   FLG_SRC_* name the two sources a flag load can pull from: the ALU
//   result flags, or the shadow copies saved when an interrupt was taken
//   (restored by RETID/RETIE).
//   flag_mux picks the load source for a single flag bit.
package rat_pkg;

  localparam logic FLG_SRC_ALU  = 1'b0;
  localparam logic FLG_SRC_SHAD = 1'b1;

  function automatic logic flag_mux(input logic sel, input logic alu_val,
                                    input logic shad_val);
    return (sel == FLG_SRC_ALU) ? alu_val : shad_val;
  endfunction

endpackage

// File: rtl/intr_sync.sv
// intr_sync
//   Brings the asynchronous external interrupt request into the CLK domain
//   and turns it into a set request for the pending latch.
// Parameters
//   SYNC_STAGES  flops in the synchroniser chain (2..4)
//   EDGE_TRIG    1: set_req is a one-cycle pulse on a rising synced edge
//                0: set_req follows the synced level
// Ports
//   clk       in   system clock, rising edge
//   reset_n   in   asynchronous active-low reset
//   intr_raw  in   external interrupt request, asynchronous to clk
//   set_req   out  request to set the pending latch (combinational)
module intr_sync #(
  parameter int SYNC_STAGES = 2,
  parameter bit EDGE_TRIG   = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic intr_raw,
  output logic set_req
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   s_q;

  // Shift chain; the oldest bit is the metastability-safe synced value.
  // All stages reset to 0 so a request still high at reset release is
  // seen as a fresh rising edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      s_q    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], intr_raw};
      s_q    <= s;
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Edge mode fires once per request; level mode keeps asking while high.
  assign set_req = EDGE_TRIG ? (s & ~s_q) : s;

endmodule

// File: rtl/flag_intr_unit.sv
// flag_intr_unit
//   Flag and interrupt front end of the RAT MCU. Holds C/Z, their shadow
//   copies and the interrupt enable under ControlUnit command, and latches
//   the synchronised external interrupt request until it is serviced.
// Parameters
//   SYNC_STAGES  synchroniser depth for INTR_RAW (2..4)
//   EDGE_TRIG    1: rising edge sets pending; 0: high level sets pending
// Ports
//   CLK, RESET_N                 clock (rising edge), async active-low reset
//   C_IN, Z_IN                   ALU result flags
//   FLG_C_SET/CLR/LD, FLG_Z_LD   flag commands from ControlUnit
//   FLG_LD_SEL                   flag load source (ALU or shadow)
//   FLG_SHAD_LD                  copy C/Z into the shadow registers
//   I_SET, I_CLR                 interrupt enable commands; I_CLR also acks
//   INTR_RAW                     external interrupt request (async)
//   C, Z, C_SHAD, Z_SHAD, I_EN   register outputs
//   INTERUPT                     pending & I_EN, to ControlUnit
module flag_intr_unit
  import rat_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter bit EDGE_TRIG   = 1'b1
) (
  input  logic CLK,
  input  logic RESET_N,
  input  logic C_IN,
  input  logic Z_IN,
  input  logic FLG_C_SET,
  input  logic FLG_C_CLR,
  input  logic FLG_C_LD,
  input  logic FLG_Z_LD,
  input  logic FLG_LD_SEL,
  input  logic FLG_SHAD_LD,
  input  logic I_SET,
  input  logic I_CLR,
  input  logic INTR_RAW,
  output logic C,
  output logic Z,
  output logic C_SHAD,
  output logic Z_SHAD,
  output logic I_EN,
  output logic INTERUPT
);

  logic set_req;
  logic pending;
  logic intr_ack;

  intr_sync #(
    .SYNC_STAGES(SYNC_STAGES),
    .EDGE_TRIG  (EDGE_TRIG)
  ) u_intr_sync (
    .clk     (CLK),
    .reset_n (RESET_N),
    .intr_raw(INTR_RAW),
    .set_req (set_req)
  );

  // Working flags. Clear beats set beats load so ControlUnit can force a
  // known carry regardless of what the ALU produces that cycle.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      C <= 1'b0;
      Z <= 1'b0;
    end else begin
      if (FLG_C_CLR)
        C <= 1'b0;
      else if (FLG_C_SET)
        C <= 1'b1;
      else if (FLG_C_LD)
        C <= flag_mux(FLG_LD_SEL, C_IN, C_SHAD);

      if (FLG_Z_LD)
        Z <= flag_mux(FLG_LD_SEL, Z_IN, Z_SHAD);
    end
  end

  // Shadow copies take the pre-edge flags, so saving and loading in the
  // same cycle swaps cleanly instead of racing.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      C_SHAD <= 1'b0;
      Z_SHAD <= 1'b0;
    end else if (FLG_SHAD_LD) begin
      C_SHAD <= C;
      Z_SHAD <= Z;
    end
  end

  // Interrupt enable: disabling has priority over enabling.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)
      I_EN <= 1'b0;
    else if (I_CLR)
      I_EN <= 1'b1 ^ 1'b1;
    else if (I_SET)
      I_EN <= 1'b1;
  end

  // Pending survives while masked. It is cleared only by the ControlUnit
  // interrupt cycle (INTERUPT high with I_CLR), and a new request arriving
  // in that same cycle keeps it set so no request is lost.
  assign intr_ack = INTERUPT & I_CLR;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)
      pending <= 1'b0;
    else if (set_req)
      pending <= 1'b1;
    else if (intr_ack)
      pending <= 1'b0;
  end

  assign INTERUPT = pending & I_EN;

endmodule

// File: tb/tb_flag_intr_unit.sv
// tb_flag_intr_unit
//   Self-checking bench for flag_intr_unit (default parameters). Directed
//   steps check fixed expected values; a random phase compares every output
//   against a behavioural model kept here.
module tb_flag_intr_unit;

  localparam int SYNC = 2;

  logic CLK = 1'b0;
  logic RESET_N;
  logic C_IN, Z_IN, FLG_C_SET, FLG_C_CLR, FLG_C_LD, FLG_Z_LD;
  logic FLG_LD_SEL, FLG_SHAD_LD, I_SET, I_CLR, INTR_RAW;
  logic C, Z, C_SHAD, Z_SHAD, I_EN, INTERUPT;

  int n_cmp  = 0;
  int n_fail = 0;

  // Behavioural model state. raw_hist[k] is INTR_RAW as sampled k+1 edges
  // ago, so the synced request seen now is the value from SYNC edges back.
  logic m_c, m_z, m_cs, m_zs, m_ien, m_pend;
  logic [3:0] raw_hist;

  flag_intr_unit dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .C_IN       (C_IN),
    .Z_IN       (Z_IN),
    .FLG_C_SET  (FLG_C_SET),
    .FLG_C_CLR  (FLG_C_CLR),
    .FLG_C_LD   (FLG_C_LD),
    .FLG_Z_LD   (FLG_Z_LD),
    .FLG_LD_SEL (FLG_LD_SEL),
    .FLG_SHAD_LD(FLG_SHAD_LD),
    .I_SET      (I_SET),
    .I_CLR      (I_CLR),
    .INTR_RAW   (INTR_RAW),
    .C          (C),
    .Z          (Z),
    .C_SHAD     (C_SHAD),
    .Z_SHAD     (Z_SHAD),
    .I_EN       (I_EN),
    .INTERUPT   (INTERUPT)
  );

  always #5 CLK = ~CLK;

  // Reset drops everything, including the request history.
  task automatic modelReset();
    m_c = 0; m_z = 0; m_cs = 0; m_zs = 0; m_ien = 0; m_pend = 0;
    raw_hist = '0;
  endtask

  // One clock edge of the rules: flags, shadow, enable, pending.
  task automatic modelEdge();
    logic fresh, fired, src_c, src_z;
    fresh = raw_hist[SYNC-1] && !raw_hist[SYNC];
    fired = m_pend && m_ien;
    src_c = FLG_LD_SEL ? m_cs : C_IN;
    src_z = FLG_LD_SEL ? m_zs : Z_IN;
    if (FLG_SHAD_LD) begin
      m_cs = m_c;
      m_zs = m_z;
    end
    if (FLG_C_CLR)      m_c = 0;
    else if (FLG_C_SET) m_c = 1;
    else if (FLG_C_LD)  m_c = src_c;
    if (FLG_Z_LD) m_z = src_z;
    m_pend = fresh || (m_pend && !(fired && I_CLR));
    if (I_CLR)      m_ien = 0;
    else if (I_SET) m_ien = 1;
    raw_hist = {raw_hist[2:0], INTR_RAW};
  endtask

  task automatic clearInputs();
    C_IN = 0; Z_IN = 0; FLG_C_SET = 0; FLG_C_CLR = 0; FLG_C_LD = 0;
    FLG_Z_LD = 0; FLG_LD_SEL = 0; FLG_SHAD_LD = 0; I_SET = 0; I_CLR = 0;
  endtask

  // Advance one clock with the currently driven inputs; sample 1 ns later.
  task automatic applyStimulus();
    modelEdge();
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %b, expected %b", tag, obs, exp);
    end
  endtask

  task automatic checkModel(input string tag);
    checkOutput({tag, ".C"},        C,        m_c);
    checkOutput({tag, ".Z"},        Z,        m_z);
    checkOutput({tag, ".C_SHAD"},   C_SHAD,   m_cs);
    checkOutput({tag, ".Z_SHAD"},   Z_SHAD,   m_zs);
    checkOutput({tag, ".I_EN"},     I_EN,     m_ien);
    checkOutput({tag, ".INTERUPT"}, INTERUPT, m_pend & m_ien);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".C"},        C,        1'b0);
    checkOutput({tag, ".Z"},        Z,        1'b0);
    checkOutput({tag, ".C_SHAD"},   C_SHAD,   1'b0);
    checkOutput({tag, ".Z_SHAD"},   Z_SHAD,   1'b0);
    checkOutput({tag, ".I_EN"},     I_EN,     1'b0);
    checkOutput({tag, ".INTERUPT"}, INTERUPT, 1'b0);
  endtask

  initial begin
    // Reset with every input high: all outputs must still read 0.
    RESET_N = 0;
    C_IN = 1; Z_IN = 1; FLG_C_SET = 1; FLG_C_CLR = 1; FLG_C_LD = 1;
    FLG_Z_LD = 1; FLG_LD_SEL = 1; FLG_SHAD_LD = 1; I_SET = 1; I_CLR = 1;
    INTR_RAW = 1;
    modelReset();
    #2;
    checkAllZero("reset_async");
    @(posedge CLK);
    @(posedge CLK);
    #1;
    checkAllZero("reset_held");
    clearInputs();
    INTR_RAW = 0;
    RESET_N = 1;
    applyStimulus();
    applyStimulus();
    checkAllZero("post_release");

    // Flag load, clear-over-set priority, Z load.
    C_IN = 1; FLG_C_LD = 1;
    applyStimulus();
    checkOutput("c_load", C, 1'b1);
    clearInputs();
    FLG_C_SET = 1; FLG_C_CLR = 1;
    applyStimulus();
    checkOutput("c_clr_over_set", C, 1'b0);
    clearInputs();
    Z_IN = 1; FLG_Z_LD = 1;
    applyStimulus();
    checkOutput("z_load", Z, 1'b1);

    // Shadow save with simultaneous load, then restore from shadow.
    clearInputs();
    FLG_C_SET = 1; FLG_Z_LD = 1; Z_IN = 0;
    applyStimulus();
    checkOutput("shad_setup_c", C, 1'b1);
    checkOutput("shad_setup_z", Z, 1'b0);
    clearInputs();
    FLG_SHAD_LD = 1; C_IN = 0; FLG_C_LD = 1;
    applyStimulus();
    checkOutput("swap_c", C, 1'b0);
    checkOutput("swap_c_shad", C_SHAD, 1'b1);
    checkOutput("swap_z_shad", Z_SHAD, 1'b0);
    clearInputs();
    FLG_LD_SEL = 1; FLG_C_LD = 1;
    applyStimulus();
    checkOutput("c_restore", C, 1'b1);

    // Enabled interrupt: fires exactly 3 edges after INTR_RAW rises.
    clearInputs();
    I_SET = 1;
    applyStimulus();
    checkOutput("ien_set", I_EN, 1'b1);
    clearInputs();
    INTR_RAW = 1;
    applyStimulus();
    checkOutput("intr_edge1", INTERUPT, 1'b0);
    applyStimulus();
    checkOutput("intr_edge2", INTERUPT, 1'b0);
    applyStimulus();
    checkOutput("intr_edge3", INTERUPT, 1'b1);
    I_CLR = 1;
    applyStimulus();
    checkOutput("ack_intr", INTERUPT, 1'b0);
    checkOutput("ack_ien", I_EN, 1'b0);
    clearInputs();
    I_SET = 1;
    applyStimulus();
    clearInputs();
    applyStimulus();
    applyStimulus();
    checkOutput("no_refire_ien", I_EN, 1'b1);
    checkOutput("no_refire", INTERUPT, 1'b0);

    // Masked request is held, then delivered when enabled.
    INTR_RAW = 0;
    for (int i = 0; i < 3; i++) applyStimulus();
    I_CLR = 1;
    applyStimulus();
    clearInputs();
    checkOutput("mask_ien", I_EN, 1'b0);
    INTR_RAW = 1;
    for (int i = 0; i < 3; i++) applyStimulus();
    INTR_RAW = 0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkOutput("masked_quiet", INTERUPT, 1'b0);
    end
    I_SET = 1;
    applyStimulus();
    clearInputs();
    checkOutput("masked_release", INTERUPT, 1'b1);

    // Async reset while interrupting; request still high at release.
    INTR_RAW = 1;
    RESET_N = 0;
    modelReset();
    #1;
    checkOutput("rst_mid_intr", INTERUPT, 1'b0);
    checkOutput("rst_mid_ien", I_EN, 1'b0);
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RESET_N = 1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkOutput("rst_fresh_quiet", INTERUPT, 1'b0);
    end
    I_SET = 1;
    applyStimulus();
    clearInputs();
    checkOutput("rst_fresh_pending", INTERUPT, 1'b1);

    // New request in the acknowledge cycle keeps pending set.
    INTR_RAW = 0;
    for (int i = 0; i < 3; i++) applyStimulus();
    INTR_RAW = 1;
    applyStimulus();
    applyStimulus();
    checkOutput("race_pre", INTERUPT, 1'b1);
    I_CLR = 1;
    applyStimulus();
    clearInputs();
    checkOutput("race_masked", INTERUPT, 1'b0);
    I_SET = 1;
    applyStimulus();
    clearInputs();
    checkOutput("race_kept", INTERUPT, 1'b1);
    I_CLR = 1;
    applyStimulus();
    clearInputs();
    checkOutput("race_ack", INTERUPT, 1'b0);

    // Random phase against the model.
    for (int n = 0; n < 300; n++) begin
      C_IN        = ($urandom_range(0, 1) == 1);
      Z_IN        = ($urandom_range(0, 1) == 1);
      FLG_C_SET   = ($urandom_range(0, 9) < 1);
      FLG_C_CLR   = ($urandom_range(0, 9) < 1);
      FLG_C_LD    = ($urandom_range(0, 9) < 3);
      FLG_Z_LD    = ($urandom_range(0, 9) < 3);
      FLG_LD_SEL  = ($urandom_range(0, 1) == 1);
      FLG_SHAD_LD = ($urandom_range(0, 9) < 2);
      I_SET       = ($urandom_range(0, 9) < 2);
      I_CLR       = ($urandom_range(0, 9) < 2);
      if ($urandom_range(0, 3) == 0) INTR_RAW = ~INTR_RAW;
      if (n == 150) begin
        RESET_N = 0;
        modelReset();
        #1;
        checkModel("rnd_reset");
        @(posedge CLK);
        #1;
        RESET_N = 1;
      end
      applyStimulus();
      checkModel("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
